wb_slave_mem: RTL and testbench
===============================

# wb_slave_mem

Pipelined Wishbone B4 slave with word-addressed RAM, programmable response latency, an outstanding-request limit and optional pseudo-random stall injection. It is the responder-side counterpart to the bus protocol checker: the simulation-side memory model that masters (ibex instruction/data ports) talk to, exercising the STALL/ACK/ERR handshake the checker validates. It is synthesizable so it can also serve as on-chip RAM.

## Interface
- AW, 32, address width (byte address)
- DW, 32, data width; fixed to 32, SEL width DW/8
- DEPTH, 1024, memory size in 32-bit words
- BASE, 32'h0, byte base address of the memory window
- LATENCY, 1, cycles from acceptance to ACK/ERR; legal range 1..8
- MAXOUT, 2, max outstanding accepted-but-unanswered requests; legal range 1..LATENCY+1

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cyc  in  1  bus cycle
- stb  in  1  strobe
- we  in  1  write enable
- adr  in  AW  byte address
- sel  in  DW/8  byte selects
- dat_m  in  DW  write data from master
- dat_s  out  DW  read data to master
- ack  out  1  normal termination
- err  out  1  error termination
- stall  out  1  slave cannot accept this cycle

## Operation
- Accept = cyc && stb && !stall, sampled at rising clk.
- Decode: word index = (adr − BASE) >> 2. Error if adr < BASE, index ≥ DEPTH, or adr[1:0] ≠ 0.
- Valid write: bytes with sel[i]=1 are written at the accepting edge; a read accepted on the next edge returns the new data. Erroring write leaves memory unchanged.
- Valid read: word captured at the accepting edge (full word, sel ignored).
- Response pipeline: LATENCY-stage delay line of {valid, err, we, data}. The last stage drives the outputs: ack = valid && !err; err = valid && err.
- dat_s is registered; it updates only when a read ACK is presented (captured data) or an ERR is presented (32'h0). Otherwise it holds.
- Outstanding counter cnt (0..MAXOUT): +1 on accept, −1 on the edge that retires the presented response; both in the same cycle leaves it unchanged.
- stall = (cnt == MAXOUT) || rnd_stall_q. Uses registered cnt, so a response retiring in the same cycle does not release stall.
- Abort: cyc low clears all valid bits in the delay line and sets cnt to 0 on the next edge. ACK/ERR are never asserted in a cycle where cyc is low. Writes already performed persist.
- Exactly one ACK or ERR per accepted request while cyc stays high; responses return in acceptance order.
- Memory contents are not reset.

## Timing
- Reset (async assert): ack=0, err=0, dat_s=0, stall=0, cnt=0, delay line cleared, rnd_stall_q=0, LFSR=16'hACE1.
- Request accepted at edge T → ACK/ERR high for exactly one cycle, the cycle following edge T+LATENCY−1. LATENCY=1 means the response is presented in the cycle right after acceptance.
- Throughput: one request per cycle when MAXOUT = LATENCY+1 and random stall is off. MAXOUT = LATENCY inserts one stall cycle every LATENCY+1 cycles.
- Reset mid-burst: all pending responses are dropped immediately; no ACK after reset release without a new accept.

## Configuration
- WB_SLAVE_RANDOM_STALL_EN defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - rnd_stall_q is set when lfsr[2:0]==0.
  - Random stall is forced low after 3 consecutive stalled cycles, so stall runs stay ≤3 cycles (well inside the checker's 16-cycle bound).
- Not defined: LFSR absent, rnd_stall_q tied 0; stall comes only from the MAXOUT limit.

## Test plan
- Single write then read, LATENCY=1, MAXOUT=2, macro off: write 32'hDEADBEEF to adr BASE+8 with sel=4'hF, then read BASE+8.
  - Required: each ACK one cycle after acceptance; read dat_s=32'hDEADBEEF; stall stays 0.
- Byte write: preload 32'h11223344, then write 32'hAABBCCDD with sel=4'b0101.
  - Required: readback is 32'h11BB33DD.
- Pipelined burst, LATENCY=3, MAXOUT=4: stb held high for 8 consecutive reads.
  - Required: 8 ACKs on consecutive cycles starting 3 cycles after the first accept, in order; stall never asserted.
- Throttling, LATENCY=3, MAXOUT=1: 4 back-to-back reads.
  - Required: stall high whenever cnt=1; each request accepted only after the previous ACK retires; exactly 4 ACKs.
- Error and abort:
  - A read at BASE+4*DEPTH gives err=1, ack=0, dat_s=0.
  - A write to a misaligned adr (BASE+1) gives err=1 and leaves memory unchanged.
  - Deasserting cyc one cycle after a LATENCY=4 accept gives no ACK, and cnt returns to 0.
- Macro on: 10,000 random reads and writes with the protocol checker attached.
  - Required: zero checker failures, no stall run longer than 3 cycles, and all read data matches a scoreboard.

Source files
------------

// File: rtl/wb_slave_mem_if.sv
// Wishbone B4 pipelined bus bundle for wb_slave_mem.
//   master modport: drives cyc, stb, we, adr, sel, dat_m; samples dat_s, ack, err, stall
//   slave  modport: the reverse
interface wb_slave_mem_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            cyc;
   logic            stb;
   logic            we;
   logic [AW-1:0]   adr;
   logic [DW/8-1:0] sel;
   logic [DW-1:0]   dat_m;
   logic [DW-1:0]   dat_s;
   logic            ack;
   logic            err;
   logic            stall;

   modport master (output cyc, stb, we, adr, sel, dat_m,
                   input  dat_s, ack, err, stall);
   modport slave  (input  cyc, stb, we, adr, sel, dat_m,
                   output dat_s, ack, err, stall);
endinterface

// File: rtl/wb_slave_mem.sv
// Pipelined Wishbone B4 slave backed by a word-addressed RAM.
// Responses come back LATENCY cycles after acceptance, at most MAXOUT
// requests may be outstanding, and cyc low aborts everything in flight.
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   bus    wb_slave_mem_if.slave (cyc/stb/we/adr/sel/dat_m in; dat_s/ack/err/stall out)
//
// Build option: define WB_SLAVE_RANDOM_STALL_EN to add LFSR-driven stall
// injection (stall runs capped at 3 cycles). Without it stall only reflects
// the outstanding-request limit.
//
// Memory contents are not reset.
module wb_slave_mem #(
   parameter int            AW      = 32,
   parameter int            DW      = 32,
   parameter int            DEPTH   = 1024,
   parameter logic [AW-1:0] BASE    = '0,
   parameter int            LATENCY = 1,
   parameter int            MAXOUT  = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   wb_slave_mem_if.slave bus
);
   localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW       = $clog2(MAXOUT + 1);
   localparam logic [CW-1:0] MAXOUT_C = CW'(MAXOUT);
   localparam logic [AW-1:0] DEPTH_C  = AW'(DEPTH);

   typedef struct packed {
      logic          v;
      logic          e;
      logic          w;
      logic [DW-1:0] d;
   } rsp_t;

   logic [DW-1:0] mem_q [DEPTH];

   logic [AW-1:0] word_off;
   logic [IW-1:0] idx;
   logic          dec_err;
   logic          acc;
   logic          stall;
   logic          retire;
   logic          rnd_stall_q;

   logic [CW-1:0] cnt_q, cnt_d;
   rsp_t          pipe_q [LATENCY];
   rsp_t          pipe_d [LATENCY];
   rsp_t          stg_in [LATENCY];
   rsp_t          rsp_in;
   rsp_t          rsp_last;
   rsp_t          rsp_next_last;
   logic [DW-1:0] dat_s_q, dat_s_d;

   // Word offset from the window base; the shift keeps every bit meaningful
   // for the range compare.
   assign word_off = (bus.adr - BASE) >> 2;
   assign idx      = word_off[IW-1:0];
   assign dec_err  = (bus.adr < BASE) || (word_off >= DEPTH_C) || (bus.adr[1:0] != 2'b00);

   // Registered count only: a response retiring this cycle does not free a slot
   // until the next edge.
   assign stall = (cnt_q == MAXOUT_C) || rnd_stall_q;
   assign acc   = bus.cyc && bus.stb && !stall;

   assign rsp_last      = pipe_q[LATENCY-1];
   assign rsp_next_last = pipe_d[LATENCY-1];
   assign retire        = rsp_last.v && bus.cyc;

   assign bus.ack   = retire && !rsp_last.e;
   assign bus.err   = retire && rsp_last.e;
   assign bus.stall = stall;
   assign bus.dat_s = dat_s_q;

   // Delay line: stage 0 takes the request being accepted; cyc low squashes
   // every valid bit so aborted requests never answer.
   always_comb begin
      rsp_in.v  = acc;
      rsp_in.e  = dec_err;
      rsp_in.w  = bus.we;
      rsp_in.d  = mem_q[idx];
      stg_in[0] = rsp_in;
      for (int k = 1; k < LATENCY; k++) begin
         stg_in[k] = pipe_q[k-1];
      end
      for (int k = 0; k < LATENCY; k++) begin
         pipe_d[k] = stg_in[k];
         if (!bus.cyc) begin
            pipe_d[k].v = 1'b0;
         end
      end
   end

   // dat_s is loaded on the edge that moves a response into the last stage, so
   // it is already valid in the cycle the ACK/ERR is presented.
   always_comb begin
      dat_s_d = dat_s_q;
      if (rsp_next_last.v) begin
         if (rsp_next_last.e) begin
            dat_s_d = '0;
         end else if (!rsp_next_last.w) begin
            dat_s_d = rsp_next_last.d;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!bus.cyc) begin
         cnt_d = '0;
      end else if (acc && !retire) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!acc && retire) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         dat_s_q <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            pipe_q[k] <= '0;
         end
      end else begin
         cnt_q   <= cnt_d;
         dat_s_q <= dat_s_d;
         for (int k = 0; k < LATENCY; k++) begin
            pipe_q[k] <= pipe_d[k];
         end
      end
   end

   // Byte-lane writes at the accepting edge; a read accepted on the next edge
   // sees the new word through the combinational read port.
   always_ff @(posedge clk_i) begin
      if (acc && bus.we && !dec_err) begin
         for (int b = 0; b < DW/8; b++) begin
            if (bus.sel[b]) begin
               mem_q[idx][8*b +: 8] <= bus.dat_m[8*b +: 8];
            end
         end
      end
   end

`ifdef WB_SLAVE_RANDOM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic [1:0]  stall_budget_q, stall_budget_d;
   logic        rnd_stall_d;

   // Fibonacci LFSR, taps 16,14,13,11. stall_budget counts down over a stall
   // run; once it hits zero random stall is held off so runs stay <= 3 cycles.
   always_comb begin
      lfsr_d         = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      stall_budget_d = 2'd3;
      if (stall) begin
         stall_budget_d = (stall_budget_q == 2'd0) ? 2'd0 : stall_budget_q - 2'd1;
      end
      rnd_stall_d = (lfsr_q[2:0] == 3'b000) && (stall_budget_d != 2'd0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q         <= 16'hACE1;
         stall_budget_q <= 2'd3;
         rnd_stall_q    <= 1'b0;
      end else begin
         lfsr_q         <= lfsr_d;
         stall_budget_q <= stall_budget_d;
         rnd_stall_q    <= rnd_stall_d;
      end
   end
`else
   assign rnd_stall_q = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave_mem.sv
module tb_wb_slave_mem;
   localparam int          NDUT          = 4;
   localparam int          LAT   [NDUT]  = '{1, 3, 3, 4};
   localparam int          MXO   [NDUT]  = '{2, 4, 1, 2};
   localparam logic [31:0] BASEA [NDUT]  = '{32'h0, 32'h4000, 32'h0, 32'h0};
`ifdef WB_SLAVE_RANDOM_STALL_EN
   localparam int          NRAND         = 10000;
`else
   localparam int          NRAND         = 400;
`endif

   typedef struct {
      bit          we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      int          gap;
   } op_t;

   typedef struct {
      int          t;
      bit          e;
      bit          w;
      logic [31:0] d;
   } exp_t;

   logic            clk;
   logic            rst;
   logic [NDUT-1:0] cyc_v;
   logic            stb, we;
   logic [31:0]     adr, dat_m;
   logic [3:0]      sel;
   logic [NDUT-1:0] ack_a, err_a, stall_a;
   logic [31:0]     dat_s_a [NDUT];

   int          n_cmp, n_err;
   op_t         ops[$];
   int          acc_edges[$];
   int          rsp_edges[$];
   int          n_stall, n_ack, n_errr;
   logic [31:0] ref_mem [NDUT][1024];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      wb_slave_mem_if #(.AW(32), .DW(32)) bus_if ();
      assign bus_if.cyc   = cyc_v[g];
      assign bus_if.stb   = stb;
      assign bus_if.we    = we;
      assign bus_if.adr   = adr;
      assign bus_if.sel   = sel;
      assign bus_if.dat_m = dat_m;
      assign ack_a[g]     = bus_if.ack;
      assign err_a[g]     = bus_if.err;
      assign stall_a[g]   = bus_if.stall;
      assign dat_s_a[g]   = bus_if.dat_s;
      wb_slave_mem #(.BASE(BASEA[g]), .LATENCY(LAT[g]), .MAXOUT(MXO[g])) u_dut (
         .clk_i (clk),
         .rst_i (rst),
         .bus   (bus_if)
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit dec_err(input int d, input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(BASEA[d]);
      return (off < 0) || ((off / 4) >= 1024) || (a[1:0] != 2'b00);
   endfunction

   function automatic int widx(input int d, input logic [31:0] a);
      return int'((a - BASEA[d]) >> 2);
   endfunction

   function automatic void push_op(input bit w, input logic [31:0] a, input logic [3:0] s,
                                   input logic [31:0] dv, input int gp);
      op_t o;
      o.we = w; o.adr = a; o.sel = s; o.dat = dv; o.gap = gp;
      ops.push_back(o);
   endfunction

   // Drives the queued ops on DUT d and checks every response against the
   // reference memory: order, latency, ack/err choice, read data and stall.
   task automatic run_ops(input int d, input int budget);
      exp_t q[$];
      exp_t x;
      op_t  op;
      int   e, gap, rnd_run;
      bit   acc, exp_st;
      e = 0; gap = 0; rnd_run = 0;
      acc_edges.delete(); rsp_edges.delete();
      n_stall = 0; n_ack = 0; n_errr = 0;
      cyc_v[d] = 1'b1;
      while ((ops.size() > 0 || q.size() > 0) && e < budget) begin
         @(negedge clk);
         exp_st = (q.size() == MXO[d]);
         if (stall_a[d]) n_stall++;
`ifdef WB_SLAVE_RANDOM_STALL_EN
         n_cmp++;
         if (exp_st && stall_a[d] !== 1'b1) begin
            n_err++; $display("FAIL stall_limit dut%0d edge %0d: stall=%b required 1", d, e, stall_a[d]);
         end
         rnd_run = (stall_a[d] && !exp_st) ? rnd_run + 1 : 0;
         n_cmp++;
         if (rnd_run > 3) begin
            n_err++; $display("FAIL stall_run dut%0d edge %0d: run=%0d required <=3", d, e, rnd_run);
         end
`else
         n_cmp++;
         if (stall_a[d] !== exp_st) begin
            n_err++; $display("FAIL stall dut%0d edge %0d: stall=%b required %b", d, e, stall_a[d], exp_st);
         end
`endif
         if (ack_a[d] || err_a[d]) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++; $display("FAIL spurious_rsp dut%0d edge %0d: ack=%b err=%b required none", d, e, ack_a[d], err_a[d]);
            end else begin
               x = q.pop_front();
               rsp_edges.push_back(e);
               if (err_a[d]) n_errr++; else n_ack++;
               if (e != x.t + LAT[d] - 1) begin
                  n_err++; $display("FAIL latency dut%0d: rsp edge %0d required %0d", d, e, x.t + LAT[d] - 1);
               end
               n_cmp++;
               if ({ack_a[d], err_a[d]} !== {!x.e, x.e}) begin
                  n_err++; $display("FAIL rsp_kind dut%0d edge %0d: ack/err=%b%b required %b%b", d, e, ack_a[d], err_a[d], !x.e, x.e);
               end
               if (x.e || !x.w) begin
                  n_cmp++;
                  if (dat_s_a[d] !== x.d) begin
                     n_err++; $display("FAIL dat_s dut%0d edge %0d: got %h required %h", d, e, dat_s_a[d], x.d);
                  end
               end
            end
         end else if (q.size() > 0 && e > q[0].t + LAT[d] - 1) begin
            n_cmp++; n_err++;
            $display("FAIL missing_rsp dut%0d edge %0d: no response for accept at edge %0d", d, e, q[0].t);
            void'(q.pop_front());
         end
         if (ops.size() > 0 && gap == 0) begin
            op = ops[0];
            stb = 1'b1; we = op.we; adr = op.adr; sel = op.sel; dat_m = op.dat;
         end else begin
            stb = 1'b0;
            if (gap > 0) gap--;
         end
         acc = stb && !stall_a[d];
         @(posedge clk);
         e++;
         if (acc) begin
            op = ops.pop_front();
            acc_edges.push_back(e);
            x.t = e; x.w = op.we; x.e = dec_err(d, op.adr); x.d = '0;
            if (!x.e) begin
               if (op.we) begin
                  for (int b = 0; b < 4; b++)
                     if (op.sel[b]) ref_mem[d][widx(d, op.adr)][8*b +: 8] = op.dat[8*b +: 8];
               end else begin
                  x.d = ref_mem[d][widx(d, op.adr)];
               end
            end
            q.push_back(x);
            gap = op.gap;
         end
      end
      stb = 1'b0;
      n_cmp++;
      if (ops.size() > 0 || q.size() > 0) begin
         n_err++; $display("FAIL timeout dut%0d: %0d ops and %0d responses pending, required 0", d, ops.size(), q.size());
      end
      ops.delete();
   endtask

   task automatic drop_cyc(input int d);
      @(negedge clk);
      cyc_v[d] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         n_cmp++;
         if ({ack_a[d], err_a[d], stall_a[d]} !== 3'b000 || dat_s_a[d] !== 32'h0) begin
            n_err++; $display("FAIL reset dut%0d: ack/err/stall=%b%b%b dat_s=%h required 000 0", d, ack_a[d], err_a[d], stall_a[d], dat_s_a[d]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_rw();
      push_op(1, 32'h8, 4'hF, 32'hDEADBEEF, 0);
      push_op(0, 32'h8, 4'hF, 32'h0, 0);
      run_ops(0, 40);
      n_cmp++;
      if (dat_s_a[0] !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL single_rw: dat_s=%h required deadbeef", dat_s_a[0]);
      end
      n_cmp++;
      if (n_stall != 0) begin
         n_err++; $display("FAIL single_rw_stall: stall cycles=%0d required 0", n_stall);
      end
      drop_cyc(0);
   endtask

   task automatic test_byte_write();
      push_op(1, 32'h20, 4'hF, 32'h11223344, 1);
      push_op(1, 32'h20, 4'b0101, 32'hAABBCCDD, 0);
      push_op(0, 32'h20, 4'h0, 32'h0, 0);
      run_ops(0, 40);
      n_cmp++;
      if (dat_s_a[0] !== 32'h11BB33DD) begin
         n_err++; $display("FAIL byte_write: dat_s=%h required 11bb33dd", dat_s_a[0]);
      end
      drop_cyc(0);
   endtask

   task automatic test_burst();
      for (int i = 0; i < 8; i++) push_op(1, BASEA[1] + 32'(4*i), 4'hF, $urandom, 0);
      run_ops(1, 80);
      for (int i = 0; i < 8; i++) push_op(0, BASEA[1] + 32'(4*(7-i)), 4'hF, 32'h0, 0);
      run_ops(1, 80);
      n_cmp++;
      if (n_ack != 8) begin
         n_err++; $display("FAIL burst_acks: got %0d required 8", n_ack);
      end
`ifndef WB_SLAVE_RANDOM_STALL_EN
      n_cmp++;
      if (n_stall != 0) begin
         n_err++; $display("FAIL burst_stall: stall cycles=%0d required 0", n_stall);
      end
      for (int i = 0; i < 8 && i < rsp_edges.size(); i++) begin
         n_cmp++;
         if (rsp_edges[i] != acc_edges[0] + 2 + i) begin
            n_err++; $display("FAIL burst_timing: rsp %0d at edge %0d required %0d", i, rsp_edges[i], acc_edges[0] + 2 + i);
         end
      end
`endif
      drop_cyc(1);
   endtask

   task automatic test_throttle();
      for (int i = 0; i < 4; i++) push_op(1, 32'(16*i), 4'hF, $urandom, 0);
      run_ops(2, 80);
      for (int i = 0; i < 4; i++) push_op(0, 32'(16*i), 4'hF, 32'h0, 0);
      run_ops(2, 80);
      n_cmp++;
      if (n_ack != 4) begin
         n_err++; $display("FAIL throttle_acks: got %0d required 4", n_ack);
      end
`ifndef WB_SLAVE_RANDOM_STALL_EN
      for (int i = 1; i < acc_edges.size(); i++) begin
         n_cmp++;
         if (acc_edges[i] - acc_edges[i-1] != LAT[2] + 1) begin
            n_err++; $display("FAIL throttle_spacing: gap %0d required %0d", acc_edges[i] - acc_edges[i-1], LAT[2] + 1);
         end
      end
`endif
      drop_cyc(2);
   endtask

   task automatic test_errors();
      push_op(1, 32'h0, 4'hF, 32'hCAFEF00D, 0);
      push_op(0, 32'd4096, 4'hF, 32'h0, 0);
      push_op(1, 32'h1, 4'hF, 32'h0, 0);
      push_op(0, 32'h0, 4'hF, 32'h0, 0);
      run_ops(0, 60);
      n_cmp++;
      if (n_errr != 2) begin
         n_err++; $display("FAIL err_count: got %0d required 2", n_errr);
      end
      n_cmp++;
      if (dat_s_a[0] !== 32'hCAFEF00D) begin
         n_err++; $display("FAIL err_write_kept: dat_s=%h required cafef00d", dat_s_a[0]);
      end
      drop_cyc(0);
      push_op(0, BASEA[1] - 32'd4, 4'hF, 32'h0, 0);
      run_ops(1, 30);
      n_cmp++;
      if (n_errr != 1 || dat_s_a[1] !== 32'h0) begin
         n_err++; $display("FAIL err_below_base: errs=%0d dat_s=%h required 1 0", n_errr, dat_s_a[1]);
      end
      drop_cyc(1);
   endtask

   task automatic test_abort();
      bit got;
      int seen;
      push_op(1, 32'h40, 4'hF, 32'h5A5A1234, 0);
      push_op(1, 32'h44, 4'hF, 32'h0BADF00D, 0);
      run_ops(3, 40);
      @(negedge clk);
      stb = 1'b1; we = 1'b0; adr = 32'h40; sel = 4'hF;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = !stall_a[3];
         @(posedge clk);
      end
      n_cmp++;
      if (!got) begin
         n_err++; $display("FAIL abort_accept: request not accepted within 20 cycles");
      end
      @(negedge clk);
      stb = 1'b0; cyc_v[3] = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack_a[3] || err_a[3]) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_err++; $display("FAIL abort_no_ack: responses=%0d required 0", seen);
      end
      push_op(0, 32'h40, 4'hF, 32'h0, 0);
      push_op(0, 32'h44, 4'hF, 32'h0, 0);
      run_ops(3, 40);
      drop_cyc(3);
   endtask

   task automatic test_reset_mid_burst();
      int seen;
      @(negedge clk);
      cyc_v[1] = 1'b1; stb = 1'b1; we = 1'b0; adr = BASEA[1]; sel = 4'hF;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ack_a[1] !== 1'b0 || err_a[1] !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_burst_in_reset: ack=%b err=%b required 0 0", ack_a[1], err_a[1]);
      end
      stb = 1'b0;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack_a[1] || err_a[1]) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_err++; $display("FAIL rst_mid_burst: responses after reset=%0d required 0", seen);
      end
      drop_cyc(1);
   endtask

   task automatic test_random(input int d, input int n);
      logic [31:0] a;
      int          r;
      for (int i = 0; i < 16; i++) push_op(1, BASEA[d] + 32'(12*i), 4'hF, $urandom, 0);
      run_ops(d, 200);
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 15);
         a = BASEA[d] + 32'(12 * $urandom_range(0, 15));
         if (r == 0) a = a + 32'($urandom_range(1, 3));
         else if (r == 1) a = BASEA[d] + 32'd4096 + 32'(4 * $urandom_range(0, 7));
         else if (r == 2) a = BASEA[d] - 32'd4;
         push_op(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
      run_ops(d, 8 * n + 100);
      drop_cyc(d);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      cyc_v = '0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_m = '0;
      rst = 1'b1;
      test_reset();
      test_single_rw();
      test_byte_write();
      test_burst();
      test_throttle();
      test_errors();
      test_abort();
      test_reset_mid_burst();
      test_random(0, NRAND);
      test_random(1, NRAND);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
